// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and elaboration-time helpers for the BCD display scanner.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
// Contents: BCD_W nibble width, BCD_BLANK code, pow10() for the overflow
// limit, clog2_min1() for index/prescaler/counter widths.
package display_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

   // 10^n as an unsigned 32-bit value; n <= 9 keeps it in range.
   function automatic int unsigned pow10(input int n);
      int unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   // Bits needed to hold 0..n-1, never less than 1 so single-entry
   // counters still get a legal vector.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Host-side bundle of the display scanner: load handshake plus display drive.
// Latency: n/a (wiring only).
// Backpressure: load is only honoured while busy=0; no queueing.
// master: host/bench drives value, load; observes busy, ovf, num, dig_sel.
// slave : scanner consumes value, load; drives busy, ovf, num, dig_sel.
interface bcd_display_scanner_if #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
);
   logic [WIDTH-1:0]  value;
   logic              load;
   logic              busy;
   logic              ovf;
   logic [3:0]        num;
   logic [DIGITS-1:0] dig_sel;

   modport master (
      output value, load,
      input  busy, ovf, num, dig_sel
   );

   modport slave (
      input  value, load,
      output busy, ovf, num, dig_sel
   );
endinterface

// File: rtl/bcd_display_scanner_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: start sampled at edge 0, WIDTH iterations on edges 1..WIDTH, done on edge WIDTH+1.
// Backpressure: start ignored while busy=1; done is a single-cycle pulse with bcd valid.
// Ports: clk, rst_n (sync, active-low), start, bin[WIDTH], busy, done, bcd[DIGITS*4].
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [WIDTH-1:0]          bin,
   output logic                      busy,
   output logic                      done,
   output logic [DIGITS*BCD_W-1:0]   bcd
);

   // One guard nibble above the displayed digits absorbs carries out of
   // the top digit; overflowing values are replaced downstream anyway.
   localparam int NIB      = DIGITS + 1;
   localparam int BCD_BITS = NIB * BCD_W;
   localparam int CNT_W    = clog2_min1(WIDTH + 1);

   logic [BCD_BITS-1:0] bcd_q;
   logic [BCD_BITS-1:0] adj;
   logic [WIDTH-1:0]    bin_q;
   logic [CNT_W-1:0]    cnt_q;

   // Add 3 to every nibble >= 5 before the shift.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NIB; i++) begin
         if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
            adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
         end
      end
   end

   // Combinational so the parent commits in the same edge busy drops.
   assign done = busy && (cnt_q == CNT_W'(WIDTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt_q <= '0;
         bcd_q <= '0;
         bin_q <= '0;
      end else if (!busy) begin
         if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
            bcd_q <= '0;
            bin_q <= bin;
         end
      end else if (done) begin
         busy <= 1'b0;
      end else begin
         bcd_q <= {adj[BCD_BITS-2:0], bin_q[WIDTH-1]};
         bin_q <= bin_q << 1;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bcd = bcd_q[DIGITS*BCD_W-1:0];

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD display feeder: converts a loaded value and time-multiplexes its digits.
// Latency: load to busy low WIDTH+1 cycles; num/dig_sel registered one cycle after scan index.
// Backpressure: load ignored while busy=1 (no queueing); display keeps old digits until commit.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: value, load, busy, ovf, num, dig_sel).
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int WIDTH       = 14,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_display_scanner_if.slave  bus
);

   localparam int          IDX_W = clog2_min1(DIGITS);
   localparam int          PRE_W = clog2_min1(REFRESH_DIV);
   localparam int unsigned LIMIT = pow10(DIGITS) - 1;

   logic                    eng_start;
   logic                    eng_busy;
   logic                    eng_done;
   logic [DIGITS*BCD_W-1:0] eng_bcd;

   logic [DIGITS*BCD_W-1:0] digits_q;
   logic                    ovf_pend_q;
   logic                    ovf_q;
   logic [PRE_W-1:0]        pre_q;
   logic [IDX_W-1:0]        idx_q;
   logic [BCD_W-1:0]        num_q;
   logic [DIGITS-1:0]       sel_q;

   logic [BCD_W-1:0]        cur_dig;
   logic                    blank;
   logic [BCD_W-1:0]        nxt_num;
   logic [DIGITS-1:0]       nxt_sel;

   assign eng_start = bus.load && !eng_busy;

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_engine (
      .clk   (clk),
      .rst_n (rst_n),
      .start (eng_start),
      .bin   (bus.value),
      .busy  (eng_busy),
      .done  (eng_done),
      .bcd   (eng_bcd)
   );

   // Overflow is judged on the sampled value, then held until commit so
   // digits and ovf flip together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         digits_q   <= '0;
      end else begin
         if (eng_start) begin
            ovf_pend_q <= (32'(bus.value) > LIMIT);
         end
         if (eng_done) begin
            digits_q <= ovf_pend_q ? {DIGITS{BCD_BLANK}} : eng_bcd;
            ovf_q    <= ovf_pend_q;
         end
      end
   end

   // Scan slot timing: free-running prescaler, index advances on wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
         pre_q <= '0;
         idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   // Outputs are built from the registered index and digits, so a commit
   // landing on a wrap shows the new digit in the new slot straight away.
   always_comb begin
      cur_dig = digits_q[idx_q*BCD_W +: BCD_W];
`ifdef LEADING_ZERO_BLANK_EN
      begin : lzb
         logic [IDX_W-1:0] msd;
         msd = '0;
         for (int i = 1; i < DIGITS; i++) begin
            if (digits_q[i*BCD_W +: BCD_W] != '0) msd = IDX_W'(i);
         end
         // Digit 0 never exceeds msd, so zero still shows "0".
         blank = !ovf_q && (idx_q > msd);
      end
`else
      blank = 1'b0;
`endif
      nxt_num = blank ? BCD_BLANK : cur_dig;
      nxt_sel = blank ? '0 : (DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num_q <= '0;
         sel_q <= '0;
      end else begin
         num_q <= nxt_num;
         sel_q <= nxt_sel;
      end
   end

   assign bus.busy    = eng_busy;
   assign bus.ovf     = ovf_q;
   assign bus.num     = num_q;
   assign bus.dig_sel = sel_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (DIGITS=4, WIDTH=14, REFRESH_DIV=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_display_scanner;
   import display_pkg::*;

   localparam int DIGITS      = 4;
   localparam int WIDTH       = 14;
   localparam int REFRESH_DIV = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   k     = 0;   // clock edges since the last reset release
   int   lat;

   always #5 clk = ~clk;

   bcd_display_scanner_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

   bcd_display_scanner #(
      .DIGITS      (DIGITS),
      .WIDTH       (WIDTH),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Accept one load and wait for busy to fall. Optionally re-pulse load
   // on busy cycle pulse_at, and check num equals hold_num on busy cycle 7.
   task automatic do_load(input logic [WIDTH-1:0] v, input int pulse_at,
                          input int hold_num, output int n);
      bus.value = v;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      check_vec("busy_rise", 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.busy && n < 40) begin
         if (n + 1 == pulse_at) begin
            bus.value = 14'd7;
            bus.load  = 1'b1;
         end
         tick();
         bus.load = 1'b0;
         n++;
         if (hold_num >= 0 && n == 7) check_vec("hold_old", 32'(bus.num), 32'(hold_num));
      end
   endtask

   // Walk 16 cycles (all four slots) and compare each slot's outputs.
   // exp_num holds {d3,d2,d1,d0}; exp_en marks slots whose select is driven.
   task automatic check_scan(input string tag, input logic [15:0] exp_num, input logic [3:0] exp_en);
      int s;
      for (int i = 0; i < 16; i++) begin
         tick();
         s = ((k - 1) / REFRESH_DIV) % DIGITS;
         check_vec({tag, "_num"}, 32'(bus.num), 32'(exp_num[s*4 +: 4]));
         check_vec({tag, "_sel"}, 32'(bus.dig_sel), exp_en[s] ? (32'd1 << s) : 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.value = '0;
      bus.load  = 1'b0;
      rst_n     = 1'b0;
      repeat (3) tick();
      check_vec("rst_busy", 32'(bus.busy), 32'd0);
      check_vec("rst_ovf", 32'(bus.ovf), 32'd0);
      check_vec("rst_num", 32'(bus.num), 32'd0);
      check_vec("rst_sel", 32'(bus.dig_sel), 32'd0);
      rst_n = 1'b1;
      k = 0;
      tick();
      check_vec("first_sel", 32'(bus.dig_sel), 32'd1);
      check_vec("first_num", 32'(bus.num), 32'd0);

      // 1: basic conversion and scan order
      do_load(14'd1234, 0, -1, lat);
      check_vec("lat_1234", 32'(lat), 32'd15);
      check_vec("ovf_1234", 32'(bus.ovf), 32'd0);
      check_scan("s1234", 16'h1234, 4'b1111);

      // 2: largest in-range value, then first overflowing value
      do_load(14'd9999, 0, -1, lat);
      check_vec("lat_9999", 32'(lat), 32'd15);
      check_vec("ovf_9999", 32'(bus.ovf), 32'd0);
      check_scan("s9999", 16'h9999, 4'b1111);
      do_load(14'd10000, 0, 9, lat);
      check_vec("lat_10000", 32'(lat), 32'd15);
      check_vec("ovf_10000", 32'(bus.ovf), 32'd1);
      check_scan("s10000", 16'hFFFF, 4'b1111);

      // 3: second load during busy is dropped
      do_load(14'd42, 5, -1, lat);
      check_vec("lat_42", 32'(lat), 32'd15);
      check_vec("ovf_42", 32'(bus.ovf), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
      check_scan("s42", 16'hFF42, 4'b0011);
`else
      check_scan("s42", 16'h0042, 4'b1111);
`endif

      // 4: zero
      do_load(14'd0, 0, -1, lat);
      check_vec("lat_0", 32'(lat), 32'd15);
`ifdef LEADING_ZERO_BLANK_EN
      check_scan("s0", 16'hFFF0, 4'b0001);
`else
      check_scan("s0", 16'h0000, 4'b1111);
`endif

      // 5: reset on the 6th busy cycle aborts the conversion
      bus.value = 14'd5678;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check_vec("abort_busy", 32'(bus.busy), 32'd0);
      check_vec("abort_sel", 32'(bus.dig_sel), 32'd0);
      check_vec("abort_num", 32'(bus.num), 32'd0);
      check_vec("abort_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      k = 0;
`ifdef LEADING_ZERO_BLANK_EN
      check_scan("s_abort", 16'hFFF0, 4'b0001);
`else
      check_scan("s_abort", 16'h0000, 4'b1111);
`endif
      check_vec("abort_busy_after", 32'(bus.busy), 32'd0);

      // 6: commit lands on the wrap into slot 0
      while (k % 16 != 0) tick();
      do_load(14'd3, 0, -1, lat);
      check_vec("lat_3", 32'(lat), 32'd15);
      check_vec("wrap_align", 32'(k % 16), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
      check_scan("s3", 16'hFFF3, 4'b0001);
`else
      check_scan("s3", 16'h0003, 4'b1111);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
